mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port, variable-latency backing memory between the instruction-fetch requester (read-only) and the data-memory requester (load/store, word or byte via MemType).
- Sits between the Fetch and Memory pipeline stages and the memory model.
- Generates per-requester stall signals; the HazardUnit ORs these into its StallF/StallPC and pipeline-freeze logic.
- Sequences one outstanding transaction at a time through an issue/wait FSM with a timeout watchdog.

Parameters:
- ADDR_W, 32, address width of both requesters and memory
- DATA_W, 32, data width
- TIMEOUT, 64, max cycles in ISSUE+WAIT before forced completion (>=4)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch read request, level, held stable until if_done
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetch read data, valid when if_done
- if_done  out  1  one-cycle completion pulse to fetch
- dm_req  in  1  data request, level, held stable until dm_done
- dm_we  in  1  1=store, 0=load
- dm_type  in  1  0=word, 1=byte (MemType encoding)
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data (byte in [7:0] when dm_type=1)
- dm_rdata  out  DATA_W  load data, valid when dm_done
- dm_done  out  1  one-cycle completion pulse to data stage
- stall_if  out  1  fetch must hold
- stall_dm  out  1  data stage (and everything upstream) must hold
- mem_req  out  1  memory request, held until mem_gnt
- mem_we  out  1  memory write enable
- mem_byte  out  1  byte access
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_gnt  in  1  memory accepted request this cycle
- mem_rvalid  in  1  completion (reads and writes), may coincide with gnt cycle+1 earliest
- mem_rdata  in  DATA_W  read data, valid with mem_rvalid
- timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; last_owner=IF; all outputs 0; rdata registers 0; timeout counter 0; timeout_err 0.
- FSM states: IDLE, ISSUE, WAIT. Owner register: IF or DM.
- IDLE: eligible request = req high and its done not high this cycle. A request whose done pulse is high this cycle is treated as already completed.
  - One eligible: grant it.
  - Both eligible: grant the one not equal to last_owner (round-robin).
  - On grant: latch addr/we/byte/wdata into mem_* registers, go to ISSUE. IF grants force we=0, byte=0.
- ISSUE: mem_req=1, mem_* outputs stable.
  - mem_gnt=1: drop mem_req next cycle, go to WAIT.
- WAIT: mem_req=0.
  - mem_rvalid=1: capture mem_rdata into owner's rdata (stores capture 0), pulse owner's done next cycle, set last_owner=owner, go to IDLE.
  - mem_rvalid in ISSUE is ignored.
- Minimum latency with zero-wait memory (gnt in ISSUE cycle, rvalid next cycle): req seen cycle 0, mem_req cycle 1, rvalid cycle 2, done cycle 3.
- Stalls are combinational: stall_x = x_req & ~x_done. Stall drops exactly in the done cycle.
- rdata holds its value until the next completion for the same requester.
- Watchdog: counter clears on entry to ISSUE and increments each cycle in ISSUE/WAIT.
  - On reaching TIMEOUT-1 without rvalid: force completion with rdata=0, done pulse, timeout_err=1 (sticky until reset), go to IDLE. mem_req deasserts.
  - If rvalid arrives in the same cycle as the timeout, rvalid wins and timeout_err is not set.
- A requester dropping req mid-transaction has no effect: the transaction completes, done still pulses.
- Reset mid-transaction aborts immediately; no done is generated.
- Both dones are never high in the same cycle.

Decomposition:
- Shared package mem_arb_pkg:
  - state enum {IDLE, ISSUE, WAIT}
  - owner enum {OWN_IF, OWN_DM}
  - MEMTYPE_WORD/MEMTYPE_BYTE constants
- Sub-module mem_arb_watchdog: counter plus compare. Inputs: clear, enable. Outputs: expire.
- Arbitration, FSM and datapath registers live in the top of the block.

Test Plan:
- Zero-wait memory, if_req only, addr 0xBFC00000, rdata 0x00500093 -> mem_req cycle 1, if_done cycle 3, if_rdata=0x00500093, stall_if high cycles 0-2.
- if_req and dm_req both rise cycle 0, last_owner=IF after reset -> DM served first (dm_done cycle 3), then IF granted cycle 3, if_done cycle 6.
- Store byte dm_addr=0x00010003, dm_wdata=0x000000AB -> mem_we=1, mem_byte=1, mem_addr=0x00010003, mem_wdata=0xAB; dm_rdata=0 on done.
- mem_gnt delayed 3 cycles, rvalid 2 cycles later -> mem_req high 4 cycles stable, done exactly 1 cycle after rvalid.
- No rvalid, TIMEOUT=64 -> done pulses after 64 cycles in ISSUE/WAIT, rdata=0, timeout_err=1 and stays 1; rvalid coincident with expiry -> no error.
- reset asserted low in WAIT -> outputs 0 immediately, no done pulse; after release, a new request completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory port arbiter: FSM states, owner
// encoding, MemType constants and the round-robin owner pick.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arbState_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  localparam logic MEMTYPE_WORD = 1'b0;
  localparam logic MEMTYPE_BYTE = 1'b1;

  // When both requesters are eligible, the one that did not finish last wins.
  function automatic owner_t pickOwner(input logic ifElig, input logic dmElig,
                                       input owner_t lastOwner);
    owner_t pick;
    if (ifElig && dmElig) begin
      if (lastOwner == OWN_IF) begin
        pick = OWN_DM;
      end else begin
        pick = OWN_IF;
      end
    end else if (dmElig) begin
      pick = OWN_DM;
    end else begin
      pick = OWN_IF;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Transaction watchdog: counts cycles spent in ISSUE/WAIT and flags expiry on
// the TIMEOUT-th cycle of a transaction.
module mem_arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] cnt;

  // Cycle counter, restarted whenever a new transaction is issued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expire = enable && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port, variable-latency memory between instruction fetch
// and the data stage, one outstanding transaction at a time.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic              dm_type,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              stall_if,
  output logic              stall_dm,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_byte,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              timeout_err
);
  arbState_t         state, stateNext;
  owner_t            owner, lastOwner, grantOwner;
  logic              ifElig, dmElig, grant, finish, timedOut;
  logic              wdEnable, wdExpire;
  logic [DATA_W-1:0] finData;

  // A requester whose done pulse is high right now is already served.
  assign ifElig   = if_req & ~if_done;
  assign dmElig   = dm_req & ~dm_done;
  assign stall_if = if_req & ~if_done;
  assign stall_dm = dm_req & ~dm_done;
  assign wdEnable = (state == ISSUE) || (state == WAIT);
  assign finData  = (timedOut || mem_we) ? '0 : mem_rdata;

  mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) uWatchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (grant),
    .enable (wdEnable),
    .expire (wdExpire)
  );

  // Arbitration and issue/wait sequencing; rvalid beats a coincident expiry.
  always_comb begin
    stateNext  = state;
    grant      = 1'b0;
    grantOwner = OWN_IF;
    finish     = 1'b0;
    timedOut   = 1'b0;
    case (state)
      IDLE: begin
        if (ifElig || dmElig) begin
          grant      = 1'b1;
          grantOwner = pickOwner(ifElig, dmElig, lastOwner);
          stateNext  = ISSUE;
        end else begin
          stateNext = IDLE;
        end
      end
      ISSUE: begin
        if (wdExpire) begin
          finish    = 1'b1;
          timedOut  = 1'b1;
          stateNext = IDLE;
        end else if (mem_gnt) begin
          stateNext = WAIT;
        end else begin
          stateNext = ISSUE;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          finish    = 1'b1;
          stateNext = IDLE;
        end else if (wdExpire) begin
          finish    = 1'b1;
          timedOut  = 1'b1;
          stateNext = IDLE;
        end else begin
          stateNext = WAIT;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // State, request latches, completion pulses and read-data capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      owner       <= OWN_IF;
      lastOwner   <= OWN_IF;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_byte    <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      if_done     <= 1'b0;
      dm_done     <= 1'b0;
      if_rdata    <= '0;
      dm_rdata    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state   <= stateNext;
      mem_req <= (stateNext == ISSUE);
      if_done <= finish && (owner == OWN_IF);
      dm_done <= finish && (owner == OWN_DM);
      if (grant) begin
        owner <= grantOwner;
        if (grantOwner == OWN_DM) begin
          mem_we    <= dm_we;
          mem_byte  <= (dm_type == MEMTYPE_BYTE);
          mem_addr  <= dm_addr;
          mem_wdata <= dm_wdata;
        end else begin
          mem_we    <= 1'b0;
          mem_byte  <= 1'b0;
          mem_addr  <= if_addr;
          mem_wdata <= '0;
        end
      end
      if (finish) begin
        lastOwner <= owner;
        if (owner == OWN_IF) begin
          if_rdata <= finData;
        end else begin
          dm_rdata <= finData;
        end
      end
      if (timedOut) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model, directed
// scenarios with literal expectations, then randomized traffic.
module tb_mem_port_arbiter;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 64;
  localparam int NEVER   = 1000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, dm_type = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_done, dm_done, stall_if, stall_dm, mem_req, mem_we, mem_byte, timeout_err;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .dm_req(dm_req), .dm_we(dm_we), .dm_type(dm_type), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_done(dm_done),
    .stall_if(stall_if), .stall_dm(stall_dm),
    .mem_req(mem_req), .mem_we(mem_we), .mem_byte(mem_byte), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .timeout_err(timeout_err)
  );

  int nChecks = 0, nFail = 0, cyc = 0;

  // Reference model: one transaction in flight, described by its age in cycles.
  bit          busy, granted, ownDm, lastDm, ifDoneE, dmDoneE, errE, prevIfDone, prevDmDone;
  bit          xWe, xByte;
  int          age, gntAge, rvAge;
  logic [31:0] xAddr, xWdata, ifRdE, dmRdE;

  // Stimulus control.
  bit          autoMode, ifBusy, dmBusy, ifKick, dmKick, dmKickWe, dmKickType;
  logic [31:0] ifKickAddr, dmKickAddr, dmKickWdata, dirData;
  int          dirGnt, dirRv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: actual %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic modelReset();
    busy = 0; granted = 0; ownDm = 0; lastDm = 0; ifDoneE = 0; dmDoneE = 0;
    errE = 0; prevIfDone = 0; prevDmDone = 0; age = 0; xWe = 0; xByte = 0;
    xAddr = '0; xWdata = '0; ifRdE = '0; dmRdE = '0;
  endtask

  task automatic pickAges();
    if (!autoMode) begin
      gntAge = dirGnt;
      rvAge  = dirRv;
    end else begin
      gntAge = ($urandom_range(0, 31) == 0) ? NEVER : int'($urandom_range(0, 3));
      case ($urandom_range(0, 15))
        0:       rvAge = NEVER;
        1:       rvAge = TIMEOUT - 1;
        default: rvAge = gntAge + 1 + int'($urandom_range(0, 3));
      endcase
    end
  endtask

  // Advance the model over the cycle that just ended at this rising edge.
  task automatic modelUpdate();
    bit eIf, eDm, fin, nIf, nDm;
    logic [31:0] data;
    prevIfDone = ifDoneE; prevDmDone = dmDoneE;
    nIf = 0; nDm = 0; fin = 0; data = '0;
    if (!busy) begin
      eIf = if_req && !ifDoneE;
      eDm = dm_req && !dmDoneE;
      if (eIf || eDm) begin
        ownDm   = eDm && (!eIf || !lastDm);
        busy    = 1; granted = 0; age = 0;
        xWe     = ownDm ? dm_we : 1'b0;
        xByte   = ownDm ? dm_type : 1'b0;
        xAddr   = ownDm ? dm_addr : if_addr;
        xWdata  = ownDm ? dm_wdata : 32'd0;
        pickAges();
      end
    end else begin
      if (granted && mem_rvalid) begin
        fin = 1; data = xWe ? 32'd0 : mem_rdata;
      end else if (age == TIMEOUT - 1) begin
        fin = 1; errE = 1;
      end else if (!granted && mem_gnt) begin
        granted = 1;
      end
      age++;
      if (fin) begin
        busy = 0; lastDm = ownDm;
        if (ownDm) begin nDm = 1; dmRdE = data; end
        else begin nIf = 1; ifRdE = data; end
      end
    end
    ifDoneE = nIf; dmDoneE = nDm;
  endtask

  task automatic driveInputs();
    if (prevIfDone) begin if_req = 0; ifBusy = 0; end
    if (prevDmDone) begin dm_req = 0; dmBusy = 0; end
    if (!ifBusy) begin
      if (ifKick) begin
        if_req = 1; if_addr = ifKickAddr; ifBusy = 1; ifKick = 0;
      end else if (autoMode && $urandom_range(0, 3) == 0) begin
        if_req = 1; if_addr = $urandom; ifBusy = 1;
      end
    end else if (autoMode && if_req && busy && !ownDm && $urandom_range(0, 15) == 0) begin
      if_req = 0;
    end
    if (!dmBusy) begin
      if (dmKick) begin
        dm_req = 1; dm_addr = dmKickAddr; dm_we = dmKickWe; dm_type = dmKickType;
        dm_wdata = dmKickWdata; dmBusy = 1; dmKick = 0;
      end else if (autoMode && $urandom_range(0, 3) == 0) begin
        dm_req = 1; dm_addr = $urandom; dm_we = 1'($urandom_range(0, 1));
        dm_type = 1'($urandom_range(0, 1)); dm_wdata = $urandom; dmBusy = 1;
      end
    end else if (autoMode && dm_req && busy && ownDm && $urandom_range(0, 15) == 0) begin
      dm_req = 0;
    end
    mem_gnt    = busy && !granted && (age == gntAge);
    mem_rvalid = (busy && granted && (age == rvAge)) ||
                 (autoMode && busy && !granted && $urandom_range(0, 3) == 0);
    mem_rdata  = autoMode ? $urandom : dirData;
  endtask

  task automatic compareAll();
    check("if_done", 32'(if_done), 32'(ifDoneE));
    check("dm_done", 32'(dm_done), 32'(dmDoneE));
    check("if_rdata", if_rdata, ifRdE);
    check("dm_rdata", dm_rdata, dmRdE);
    check("timeout_err", 32'(timeout_err), 32'(errE));
    check("stall_if", 32'(stall_if), 32'(if_req & ~ifDoneE));
    check("stall_dm", 32'(stall_dm), 32'(dm_req & ~dmDoneE));
    check("mem_req", 32'(mem_req), 32'(busy && !granted));
    if (busy && !granted) begin
      check("mem_we", 32'(mem_we), 32'(xWe));
      check("mem_byte", 32'(mem_byte), 32'(xByte));
      check("mem_addr", mem_addr, xAddr);
      check("mem_wdata", mem_wdata, xWdata);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) modelUpdate();
    cyc++;
    #1 driveInputs();
    @(negedge clk);
    if (reset) compareAll();
  endtask

  task automatic waitDone(input bit dm, input int limit, output int at);
    at = -1000;
    for (int i = 0; i < limit; i++) begin
      step();
      if ((dm ? dm_done : if_done) == 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    autoMode = 0;
    while ((busy || ifBusy || dmBusy) && n < 400) begin step(); n++; end
    check("drain bound", 32'(busy || ifBusy || dmBusy), 32'd0);
  endtask

  int c0, at, atIf, reqCnt;
  bit addrOk;

  initial begin
    modelReset();
    autoMode = 0; ifBusy = 0; dmBusy = 0; ifKick = 0; dmKick = 0;
    dirGnt = 0; dirRv = 1; dirData = 32'h00500093;
    repeat (2) step();
    check("rst mem_req", 32'(mem_req), 32'd0);
    check("rst if_done", 32'(if_done), 32'd0);
    check("rst rdata", if_rdata | dm_rdata, 32'd0);
    check("rst timeout_err", 32'(timeout_err), 32'd0);
    reset = 1'b1;
    step();

    // Simultaneous requests after reset: DM first, then IF.
    dirData = 32'hCAFE0001;
    ifKick = 1; ifKickAddr = 32'h00000100;
    dmKick = 1; dmKickAddr = 32'h00001000; dmKickWe = 0; dmKickType = 0; dmKickWdata = '0;
    step(); c0 = cyc;
    waitDone(1'b1, 10, at);
    check("t2 dm_done cycle", 32'(at - c0), 32'd3);
    check("t2 dm_rdata", dm_rdata, 32'hCAFE0001);
    waitDone(1'b0, 10, atIf);
    check("t2 if_done cycle", 32'(atIf - c0), 32'd6);
    repeat (2) step();

    // Zero-wait fetch.
    dirData = 32'h00500093;
    ifKick = 1; ifKickAddr = 32'hBFC00000;
    step(); c0 = cyc;
    check("t1 stall_if c0", 32'(stall_if), 32'd1);
    check("t1 mem_req c0", 32'(mem_req), 32'd0);
    step();
    check("t1 mem_req c1", 32'(mem_req), 32'd1);
    check("t1 mem_addr c1", mem_addr, 32'hBFC00000);
    waitDone(1'b0, 10, at);
    check("t1 if_done cycle", 32'(at - c0), 32'd3);
    check("t1 if_rdata", if_rdata, 32'h00500093);
    check("t1 stall_if done", 32'(stall_if), 32'd0);
    repeat (2) step();

    // Byte store.
    dmKick = 1; dmKickAddr = 32'h00010003; dmKickWe = 1; dmKickType = 1; dmKickWdata = 32'h000000AB;
    step(); c0 = cyc;
    step();
    check("t3 mem_we", 32'(mem_we), 32'd1);
    check("t3 mem_byte", 32'(mem_byte), 32'd1);
    check("t3 mem_addr", mem_addr, 32'h00010003);
    check("t3 mem_wdata", mem_wdata, 32'h000000AB);
    waitDone(1'b1, 10, at);
    check("t3 dm_done cycle", 32'(at - c0), 32'd3);
    check("t3 dm_rdata", dm_rdata, 32'd0);
    repeat (2) step();

    // Grant delayed three cycles, rvalid two cycles after grant.
    dirGnt = 3; dirRv = 5;
    ifKick = 1; ifKickAddr = 32'h00400010;
    step(); c0 = cyc; reqCnt = 0; addrOk = 1; at = -1000;
    for (int i = 0; i < 20 && at < 0; i++) begin
      step();
      if (mem_req) begin
        reqCnt++;
        if (mem_addr !== 32'h00400010) addrOk = 0;
      end
      if (if_done) at = cyc;
    end
    check("t4 mem_req cycles", 32'(reqCnt), 32'd4);
    check("t4 mem_addr stable", 32'(addrOk), 32'd1);
    check("t4 if_done cycle", 32'(at - c0), 32'd7);
    repeat (2) step();

    // rvalid on the expiry cycle: normal completion, no error.
    dirGnt = 0; dirRv = TIMEOUT - 1;
    ifKick = 1; ifKickAddr = 32'h00400020;
    step(); c0 = cyc;
    waitDone(1'b0, 100, at);
    check("t5a done cycle", 32'(at - c0), 32'd65);
    check("t5a if_rdata", if_rdata, 32'h00500093);
    check("t5a timeout_err", 32'(timeout_err), 32'd0);
    repeat (2) step();

    // No rvalid at all: forced completion.
    dirRv = NEVER;
    ifKick = 1; ifKickAddr = 32'h00400030;
    step(); c0 = cyc;
    waitDone(1'b0, 100, at);
    check("t5b done cycle", 32'(at - c0), 32'd65);
    check("t5b if_rdata", if_rdata, 32'd0);
    check("t5b timeout_err", 32'(timeout_err), 32'd1);
    repeat (5) step();
    check("t5b err sticky", 32'(timeout_err), 32'd1);

    autoMode = 1;
    repeat (4000) step();
    drain();

    // Reset while waiting for rvalid.
    dirGnt = 0; dirRv = 1; dirData = 32'h5A5A1234;
    dmKick = 1; dmKickAddr = 32'h00020000; dmKickWe = 0; dmKickType = 0; dmKickWdata = '0;
    step();
    waitDone(1'b1, 10, at);
    check("t6 dm_rdata pre", dm_rdata, 32'h5A5A1234);
    repeat (2) step();
    dirRv = NEVER;
    dmKick = 1; dmKickAddr = 32'h00020040;
    repeat (3) step();
    check("t6 in wait", 32'(busy && granted), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("t6 rst dm_rdata", dm_rdata, 32'd0);
    check("t6 rst mem_addr", mem_addr, 32'd0);
    check("t6 rst timeout_err", 32'(timeout_err), 32'd0);
    check("t6 rst dm_done", 32'(dm_done), 32'd0);
    modelReset();
    if_req = 0; dm_req = 0; ifBusy = 0; dmBusy = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6 no done in reset", 32'(dm_done | if_done), 32'd0);
    end
    reset = 1'b1;
    dirRv = 1;
    ifKick = 1; ifKickAddr = 32'hBFC00004;
    step(); c0 = cyc;
    waitDone(1'b0, 10, at);
    check("t6 post-reset done cycle", 32'(at - c0), 32'd3);
    check("t6 post-reset if_rdata", if_rdata, 32'h5A5A1234);
    repeat (2) step();

    autoMode = 1;
    repeat (1500) step();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
